// File: rtl/dtrig_dac_sched.sv
// dtrig_dac_sched
//   Schedules L0 digital-trigger threshold writes from the host command path and the
//   rate-feedback loop onto the single serial DAC link. Keeps an 8-bit shadow threshold
//   per channel, serialises 16-bit DAC frames MSB first, closes every write burst with
//   one DAC update frame and runs an automatic init sequence after reset or on reinit.
//
//   Optional build macro DTRIG_DAC_DEDUP_EN: a request whose value already matches the
//   shadow of a valid channel is acknowledged without sending a frame.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   host_req/ch/val/ack    host write request (held until ack), one-cycle ack pulse
//   fb_req/ch/val/ack      feedback write request (held until ack), one-cycle ack pulse
//   reinit                 pulse: rerun the full init sequence
//   sc_en, sc_clk, sc_din  DAC chip select (active low), serial clock, serial data
//   busy                   frame in flight or pending, or init not yet complete
//   init_done              high once the init sequence has completed
//   bad_ch                 one-cycle pulse when an accepted request targets ch >= NCH
//   thr_shadow             packed shadow thresholds, ch0 in [7:0]
module dtrig_dac_sched #(
    parameter int unsigned NCH      = 7,
    parameter int unsigned SCLK_DIV = 1,
    parameter int unsigned CS_GAP   = 2,
    parameter logic [7:0]  DEF_THR  = 8'd100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic [2:0]       host_ch,
    input  logic [7:0]       host_val,
    output logic             host_ack,
    input  logic             fb_req,
    input  logic [2:0]       fb_ch,
    input  logic [7:0]       fb_val,
    output logic             fb_ack,
    input  logic             reinit,
    output logic             sc_en,
    output logic             sc_clk,
    output logic             sc_din,
    output logic             busy,
    output logic             init_done,
    output logic             bad_ch,
    output logic [8*NCH-1:0] thr_shadow
);

    localparam int unsigned IdxW = $clog2(NCH + 2);
    localparam int unsigned DivW = $clog2(SCLK_DIV + 1);
    localparam int unsigned GapW = $clog2(CS_GAP + 1);

    localparam logic [15:0] FrmPowerDown = 16'hD080;
    localparam logic [15:0] FrmUpdate    = 16'hA07F;

    typedef enum logic [2:0] {StInitQ, StIdle, StLoad, StShift, StGap} state_e;

    state_e          state_q, state_d;
    logic [15:0]     sh_q, sh_d;
    logic [3:0]      bit_q, bit_d;
    logic [DivW-1:0] div_q, div_d;
    logic            phase_q, phase_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            init_done_q, init_done_d;
    logic            reinit_pend_q, reinit_pend_d;
    logic            pend_upd_q, pend_upd_d;
    logic            rr_q, rr_d;
    logic [7:0]      shadow_q [NCH];
    logic [7:0]      shadow_d [NCH];
    logic            sc_en_q, sc_clk_q, sc_din_q, busy_q;

    logic            grant_fb, any_req, g_bad, g_same;
    logic [2:0]      g_ch;
    logic [7:0]      g_val;
    logic            decide, load_init, in_frame_d;
    logic [7:0]      init_val;
    logic [15:0]     init_frame;

    // Round-robin: rr_q=1 means fb wins a tie (host was granted last).
    assign any_req  = host_req | fb_req;
    assign grant_fb = fb_req & (~host_req | rr_q);
    assign g_ch     = grant_fb ? fb_ch : host_ch;
    assign g_val    = grant_fb ? fb_val : host_val;
    assign g_bad    = (32'(g_ch) >= NCH);

`ifdef DTRIG_DAC_DEDUP_EN
    logic [7:0] g_cur;
    always_comb begin
        g_cur = DEF_THR;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(g_ch) == i) g_cur = shadow_q[i];
        end
    end
    assign g_same = (g_val == g_cur);
`else
    assign g_same = 1'b0;
`endif

    // Init sequence: data frames ch0..NCH-1 from shadow, then power-down, then update.
    always_comb begin
        init_val = DEF_THR;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(idx_q) == i) init_val = shadow_q[i];
        end
        if (32'(idx_q) < NCH) begin
            init_frame = {4'(idx_q), init_val, 4'h0};
        end else if (32'(idx_q) == NCH) begin
            init_frame = FrmPowerDown;
        end else begin
            init_frame = FrmUpdate;
        end
    end

    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        bit_d         = bit_q;
        div_d         = div_q;
        phase_d       = phase_q;
        gap_d         = gap_q;
        idx_d         = idx_q;
        init_done_d   = init_done_q;
        reinit_pend_d = reinit_pend_q | reinit;
        pend_upd_d    = pend_upd_q;
        rr_d          = rr_q;
        shadow_d      = shadow_q;
        host_ack      = 1'b0;
        fb_ack        = 1'b0;
        bad_ch        = 1'b0;
        decide        = 1'b0;
        load_init     = 1'b0;

        unique case (state_q)
            StInitQ: begin
                reinit_pend_d = 1'b0;
                load_init     = 1'b1;
            end
            StIdle: decide = 1'b1;
            StLoad: begin
                state_d = StShift;
                bit_d   = 4'd0;
                div_d   = '0;
                phase_d = 1'b0;
            end
            StShift: begin
                if (div_q == DivW'(SCLK_DIV - 1)) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        // End of the 16th high phase: release chip select.
                        state_d = StGap;
                        gap_d   = '0;
                        if (!init_done_q && (32'(idx_q) == NCH + 2)) init_done_d = 1'b1;
                    end else begin
                        // Data advances on the falling sc_clk edge.
                        bit_d   = bit_q + 4'd1;
                        phase_d = 1'b0;
                        sh_d    = {sh_q[14:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapW'(CS_GAP - 1)) begin
                    decide = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (decide) begin
            state_d = StIdle;
            if (reinit_pend_q || reinit) begin
                reinit_pend_d = 1'b0;
                init_done_d   = 1'b0;
                idx_d         = '0;
                state_d       = StInitQ;
            end else if (!init_done_q) begin
                load_init = 1'b1;
            end else if (any_req) begin
                host_ack = ~grant_fb;
                fb_ack   = grant_fb;
                rr_d     = ~grant_fb;
                if (g_bad) begin
                    bad_ch = 1'b1;
                end else if (!g_same) begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (32'(g_ch) == i) shadow_d[i] = g_val;
                    end
                    sh_d       = {1'b0, g_ch, g_val, 4'h0};
                    pend_upd_d = 1'b1;
                    state_d    = StLoad;
                end
            end else if (pend_upd_q) begin
                sh_d       = FrmUpdate;
                pend_upd_d = 1'b0;
                state_d    = StLoad;
            end
        end

        if (load_init) begin
            sh_d    = init_frame;
            idx_d   = idx_q + IdxW'(1);
            state_d = StLoad;
            // The init update frame also covers any burst still awaiting its update.
            if (32'(idx_q) == NCH + 1) pend_upd_d = 1'b0;
        end
    end

    assign in_frame_d = (state_d == StLoad) || (state_d == StShift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StInitQ;
            sh_q          <= '0;
            bit_q         <= '0;
            div_q         <= '0;
            phase_q       <= 1'b0;
            gap_q         <= '0;
            idx_q         <= '0;
            init_done_q   <= 1'b0;
            reinit_pend_q <= 1'b0;
            pend_upd_q    <= 1'b0;
            rr_q          <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) shadow_q[i] <= DEF_THR;
            sc_en_q       <= 1'b1;
            sc_clk_q      <= 1'b0;
            sc_din_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            bit_q         <= bit_d;
            div_q         <= div_d;
            phase_q       <= phase_d;
            gap_q         <= gap_d;
            idx_q         <= idx_d;
            init_done_q   <= init_done_d;
            reinit_pend_q <= reinit_pend_d;
            pend_upd_q    <= pend_upd_d;
            rr_q          <= rr_d;
            shadow_q      <= shadow_d;
            // Pin drivers come straight from flops so sc_clk/sc_en cannot glitch.
            sc_en_q       <= ~in_frame_d;
            sc_clk_q      <= (state_d == StShift) & phase_d;
            sc_din_q      <= in_frame_d & sh_d[15];
            busy_q        <= (state_d != StIdle) | pend_upd_d | ~init_done_d;
        end
    end

    always_comb begin
        thr_shadow = '0;
        for (int unsigned i = 0; i < NCH; i++) thr_shadow[8*i +: 8] = shadow_q[i];
    end

    assign sc_en     = sc_en_q;
    assign sc_clk    = sc_clk_q;
    assign sc_din    = sc_din_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule

// File: doc/dtrig_dac_sched.md
Name: dtrig_dac_sched

Overview:
- Arbitrates L0 digital-trigger threshold writes from two requesters, host command path and rate-feedback loop, onto the single serial DAC link (L1_SC_*).
- Keeps an 8-bit shadow threshold per channel (ch0–6) and serialises 16-bit DAC frames.
- Issues one DAC update frame at the end of each write burst, and runs an automatic init sequence after reset.
- Sits between the slow-control register file / rate monitor and the DAC pins on the readout board.

Parameters:
- NCH, 7, number of threshold channels; addresses 0..NCH-1 are valid.
- SCLK_DIV, 1, sc_clk half-period in clk cycles (≥1).
- CS_GAP, 2, clk cycles sc_en held high between frames (≥1).
- DEF_THR, 8'd100, shadow value loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host write request; held until host_ack
- host_ch  in  3  host target channel
- host_val  in  8  host threshold value
- host_ack  out  1  one-cycle accept pulse
- fb_req  in  1  feedback write request; held until fb_ack
- fb_ch  in  3  feedback target channel
- fb_val  in  8  feedback threshold value
- fb_ack  out  1  one-cycle accept pulse
- reinit  in  1  pulse: rerun full init sequence
- sc_en  out  1  DAC chip select, active low
- sc_clk  out  1  DAC serial clock
- sc_din  out  1  DAC serial data, MSB first
- busy  out  1  high while any frame is in flight or pending
- init_done  out  1  high after init sequence completes; low during init
- bad_ch  out  1  one-cycle pulse when an accepted request has ch ≥ NCH
- thr_shadow  out  8*NCH  packed shadow values; ch0 in [7:0]

Behaviour:
- Reset (rst_n=0, asynchronous): sc_en=1, sc_clk=0, sc_din=0, acks=0, busy=0, init_done=0, bad_ch=0, all shadows=DEF_THR, FSM=INIT_Q. A reset mid-frame aborts the frame immediately.
- Frame formats:
  - Data: {ch[3:0], val[7:0], 4'h0}.
  - Ch7 power-down: {4'b1101, 4'h0, 8'h80}.
  - Update: {4'b1010, 4'h0, 8'h7F}.
- Init sequence: data frames ch0..NCH-1 from shadow, then power-down frame, then update frame; then init_done=1.
- While init_done=0, no acks are issued. Requests stay pending.
- reinit while idle: clear init_done and rerun init. reinit during a frame: latch it and start init after the current frame completes.
- FSM states: INIT_Q, IDLE, LOAD, SHIFT, GAP.
  - LOAD (1 cycle): sc_en←0, sc_din←bit15, sc_clk=0.
  - SHIFT: per bit, SCLK_DIV cycles with sc_clk=0, then SCLK_DIV cycles with sc_clk=1. The DAC samples on the sc_clk rising edge. sc_din advances to the next bit when sc_clk falls.
  - Frame end: after the 16th high phase, sc_clk←0 and sc_en←1 in the same cycle. sc_en is low for exactly 1+32*SCLK_DIV cycles (33 at default).
  - GAP: CS_GAP cycles, then next LOAD, or IDLE if nothing is queued.
- Arbitration: evaluated in IDLE and on the last GAP cycle.
  - Round-robin between host and fb. The last-granted requester gets lower priority on a tie. Priority pointer reset value: host first.
  - The ack pulse occurs in the cycle the frame is latched (entry to LOAD).
  - The shadow updates in the same cycle as the ack.
- Update rule: a pending-update flag sets on each data frame. If no request is present at grant time and the flag is set, send the update frame and clear the flag. A burst of N back-to-back writes therefore yields N data frames plus 1 update.
- Bad channel: request with ch ≥ NCH is acked with bad_ch pulsed in the same cycle. No frame is sent, the shadow is unchanged, and the FSM stays IDLE.
- Same-channel back-to-back writes are each sent in order. The last value wins in the shadow.
- busy = (FSM≠IDLE) | pending-update | (~init_done).

Optional Feature:
- Macro: DTRIG_DAC_DEDUP_EN.
- When defined: a request whose val equals the current shadow of a valid ch is acked in IDLE within 1 cycle. No frame is sent and pending-update is not set.
- When undefined: every valid request produces a data frame.

Test Plan:
- Reset release, SCLK_DIV=1, CS_GAP=2 -> 9 frames: ch0..6 = {ch,8'd100,4'h0}, then 16'hD080, then 16'hA07F. init_done rises after the last frame. Each sc_en low window is 33 cycles; gaps between frames are 2 cycles.
- After init, host_req ch3 val 8'h55 -> host_ack within 1 cycle, frame 16'h3550, then 16'hA07F. thr_shadow[31:24]=8'h55.
- host and fb requesting simultaneously and continuously -> grants alternate host, fb, host, fb. No update frame until both drop. Exactly one 16'hA07F follows.
- fb_req ch 7 -> fb_ack and bad_ch pulse in the same cycle. No sc_en activity. Shadow unchanged.
- rst_n pulsed low during bit 8 of a frame -> sc_en=1 and sc_clk=0 immediately. Init sequence restarts with ch0 after release.
- With DTRIG_DAC_DEDUP_EN, host writes ch2 val 100 -> ack with no frame. Then val 101 -> frame 16'h2650 plus update.
